warp_align: RTL



---
 rtl/warp_pkg.sv | 14 +
 rtl/warp_ilen.sv | 16 +
 rtl/warp_align.sv | 120 ++++++++++++
 3 files changed

// File: rtl/warp_pkg.sv
// Shared constants for the warp front end: instruction and halfword widths,
// plus the low-bit tag that marks a full-length (non-compressed) encoding.
package warp_pkg;

    localparam int WARP_ILEN = 32;
    localparam int HALF_W    = 16;

    localparam logic [1:0] ILEN32_TAG = 2'b11;

    function automatic logic half_is_compressed(input logic [HALF_W-1:0] half);
        return half[1:0] != ILEN32_TAG;
    endfunction

endpackage

// File: rtl/warp_ilen.sv
// Length detect for the halfword that starts an instruction.
// Purely combinational, zero latency, no flow control.
module warp_ilen
    import warp_pkg::*;
(
    input  logic [HALF_W-1:0] half,
    output logic              is_compressed
);

    // Only the two tag bits decide length; the rest of the halfword is opcode payload.
    logic unused_payload;

    assign is_compressed  = half_is_compressed(half);
    assign unused_payload = ^half[HALF_W-1:2];

endmodule

// File: rtl/warp_align.sv
// Aligns 32-bit fetch words into one 16- or 32-bit instruction per cycle.
// Latency: a word accepted in cycle N can be presented in cycle N+1.
// Backpressure: fetch ready only while at most two halfwords are buffered.
module warp_align
    import warp_pkg::*;
#(
    parameter int             PCW      = 64,
    parameter logic [PCW-1:0] RESET_PC = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_fetch_valid,
    output logic                 o_fetch_ready,
    input  logic [31:0]          i_fetch_word,
    input  logic                 i_flush,
    input  logic [PCW-1:0]       i_flush_pc,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WARP_ILEN-1:0] o_inst,
    output logic                 o_compressed,
    output logic [PCW-1:0]       o_pc
);

    logic [HALF_W-1:0] hbuf     [4];
    logic [HALF_W-1:0] shifted  [4];
    logic [HALF_W-1:0] nxt_buf  [4];
    logic [2:0]        count;
    logic [2:0]        nshift;
    logic [2:0]        rem;
    logic [2:0]        nxt_count;
    logic [PCW-1:0]    head_pc;
    logic [PCW-1:0]    pc_step;
    logic              drop_half;

    logic              head_c;
    logic              have_inst;
    logic              consume;
    logic              enq;
    logic [HALF_W-1:0] word_lo;
    logic [HALF_W-1:0] word_hi;

    warp_ilen u_ilen (
        .half          (hbuf[0]),
        .is_compressed (head_c)
    );

    assign have_inst = head_c ? (count != 3'd0) : (count >= 3'd2);

    assign o_valid       = have_inst && !i_flush;
    assign o_compressed  = head_c;
    assign o_pc          = head_pc;
    assign o_inst        = head_c ? {{(WARP_ILEN-HALF_W){1'b0}}, hbuf[0]}
                                  : {hbuf[1], hbuf[0]};
    assign o_fetch_ready = (count <= 3'd2);

    assign consume = o_valid && i_ready;
    assign enq     = i_fetch_valid && o_fetch_ready && !i_flush;
    assign word_lo = i_fetch_word[HALF_W-1:0];
    assign word_hi = i_fetch_word[31:HALF_W];

    assign nshift  = !consume ? 3'd0 : (head_c ? 3'd1 : 3'd2);
    assign pc_step = head_c ? PCW'(2) : PCW'(4);

    // Retire from the head first, then append the new halfwords after whatever remains.
    always_comb begin
        shifted = hbuf;
        case (nshift)
            3'd1: begin
                shifted[0] = hbuf[1];
                shifted[1] = hbuf[2];
                shifted[2] = hbuf[3];
            end
            3'd2: begin
                shifted[0] = hbuf[2];
                shifted[1] = hbuf[3];
            end
            default: ;
        endcase

        rem     = count - nshift;
        nxt_buf = shifted;
        if (enq) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) == rem) begin
                    nxt_buf[i] = drop_half ? word_hi : word_lo;
                end else if (!drop_half && (3'(i) == rem + 3'd1)) begin
                    nxt_buf[i] = word_hi;
                end
            end
        end

        nxt_count = rem + (enq ? (drop_half ? 3'd1 : 3'd2) : 3'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count     <= 3'd0;
            head_pc   <= RESET_PC;
            drop_half <= RESET_PC[1];
            for (int i = 0; i < 4; i++) begin
                hbuf[i] <= '0;
            end
        end else if (i_flush) begin
            // A target on the upper halfword means the first word's lower half is stale.
            count     <= 3'd0;
            head_pc   <= i_flush_pc;
            drop_half <= i_flush_pc[1];
        end else begin
            hbuf  <= nxt_buf;
            count <= nxt_count;
            if (consume) begin
                head_pc <= head_pc + pc_step;
            end
            if (enq && drop_half) begin
                drop_half <= 1'b0;
            end
        end
    end

endmodule
